// File: rtl/auv_timer_pkg.sv
// Shared definitions for the Wishbone prescaled down-counter timer.
package auv_timer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADR_W  = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [2:0] {
        IDX_CTRL      = 3'd0,
        IDX_STATUS    = 3'd1,
        IDX_PRESC     = 3'd2,
        IDX_RELOAD_LO = 3'd3,
        IDX_RELOAD_HI = 3'd4,
        IDX_COUNT_LO  = 3'd5,
        IDX_COUNT_HI  = 3'd6,
        IDX_RSVD      = 3'd7
    } reg_idx_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IE      = 1;
    localparam int unsigned CTRL_ONESHOT = 2;
    localparam int unsigned CTRL_W       = 3;
    localparam int unsigned STATUS_IF    = 0;

    // Merge a 16-bit write into an existing value under the byte-lane mask.
    function automatic logic [DATA_W-1:0] apply_sel(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [SEL_W-1:0]  sel
    );
        return {sel[1] ? new_val[15:8] : old_val[15:8],
                sel[0] ? new_val[7:0]  : old_val[7:0]};
    endfunction

endpackage

// File: rtl/auv_timer_prescaler.sv
// Prescaler: counts 0..presc while enabled and flags the cycle it reaches presc.
module auv_timer_prescaler #(
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] presc,
    input  logic                   restart,
    output logic                   tick_c
);

    logic [PRESC_WIDTH-1:0] cnt;

    assign tick_c = en && (cnt == presc);

    // Disabled or reprogrammed prescaler parks at 0 so the next period is full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !en || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/auv_wb_timer.sv
// Pipelined Wishbone responder exposing a prescaled down-counter timer with
// reload, one-shot mode, W1C interrupt flag and tear-free COUNT reads.
module auv_wb_timer
    import auv_timer_pkg::*;
#(
    parameter int unsigned          COUNT_WIDTH = 32,
    parameter int unsigned          PRESC_WIDTH = 16,
    parameter logic [COUNT_WIDTH-1:0] RST_RELOAD = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o,
    output logic        irq_o
);

    logic [CTRL_W-1:0]      ctrl,   ctrl_d;
    logic                   if_q,   if_d;
    logic [PRESC_WIDTH-1:0] presc,  presc_d;
    logic [COUNT_WIDTH-1:0] reload, reload_d;
    logic [COUNT_WIDTH-1:0] count,  count_d;
    logic [DATA_W-1:0]      shadow, shadow_d;
    logic [DATA_W-1:0]      dat_d;
    logic                   ack_d, err_d;

    logic        acc, wr, rd;
    reg_idx_e    idx;
    logic        tick_c, expire_c, count_wr_c, presc_restart_c;
    logic [31:0] count_ext, reload_ext;
    logic [15:0] cnt_lo_new, cnt_hi_new, rl_lo_new, rl_hi_new, rdata;
    logic        unused_adr0;

    assign acc         = wb_cyc_i & wb_stb_i;
    assign wr          = acc & wb_we_i;
    assign rd          = acc & ~wb_we_i;
    assign idx         = reg_idx_e'(wb_adr_i[3:1]);
    assign unused_adr0 = wb_adr_i[0];
    assign wb_stall_o  = 1'b0;

    assign count_ext  = 32'(count);
    assign reload_ext = 32'(reload);

    assign count_wr_c      = wr && (idx == IDX_COUNT_LO || idx == IDX_COUNT_HI);
    assign presc_restart_c = wr && (idx == IDX_PRESC);
    // A software COUNT write overrides whatever the tick would have done.
    assign expire_c        = tick_c && (count == '0) && !count_wr_c;

    auv_timer_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ctrl[CTRL_EN]),
        .presc   (presc),
        .restart (presc_restart_c),
        .tick_c  (tick_c)
    );

    // Read mux reflects state before the accepting edge.
    always_comb begin
        rdata = '0;
        case (idx)
            IDX_CTRL:      rdata = 16'(ctrl);
            IDX_STATUS:    rdata = 16'(if_q);
            IDX_PRESC:     rdata = 16'(presc);
            IDX_RELOAD_LO: rdata = reload_ext[15:0];
            IDX_RELOAD_HI: rdata = reload_ext[31:16];
            IDX_COUNT_LO:  rdata = count_ext[15:0];
            IDX_COUNT_HI:  rdata = shadow;
            default:       rdata = '0;
        endcase
    end

    // Next-state for registers, counter and bus response.
    always_comb begin
        ctrl_d     = ctrl;
        if_d       = if_q;
        presc_d    = presc;
        reload_d   = reload;
        count_d    = count;
        shadow_d   = shadow;
        cnt_lo_new = apply_sel(count_ext[15:0],   wb_dat_i, wb_sel_i);
        cnt_hi_new = apply_sel(count_ext[31:16],  wb_dat_i, wb_sel_i);
        rl_lo_new  = apply_sel(reload_ext[15:0],  wb_dat_i, wb_sel_i);
        rl_hi_new  = apply_sel(reload_ext[31:16], wb_dat_i, wb_sel_i);

        if (count_wr_c) begin
            count_d = (idx == IDX_COUNT_LO) ? COUNT_WIDTH'({count_ext[31:16], cnt_lo_new})
                                            : COUNT_WIDTH'({cnt_hi_new, count_ext[15:0]});
        end else if (tick_c) begin
            count_d = expire_c ? reload : count - COUNT_WIDTH'(1);
        end

        if (wr && idx == IDX_CTRL && wb_sel_i[0]) begin
            ctrl_d = wb_dat_i[CTRL_W-1:0];
        end else if (expire_c && ctrl[CTRL_ONESHOT]) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end

        if (expire_c) begin
            if_d = 1'b1;
        end else if (wr && idx == IDX_STATUS && wb_sel_i[0] && wb_dat_i[STATUS_IF]) begin
            if_d = 1'b0;
        end

        if (presc_restart_c) begin
            presc_d = PRESC_WIDTH'(apply_sel(16'(presc), wb_dat_i, wb_sel_i));
        end
        if (wr && idx == IDX_RELOAD_LO) begin
            reload_d = COUNT_WIDTH'({reload_ext[31:16], rl_lo_new});
        end else if (wr && idx == IDX_RELOAD_HI) begin
            reload_d = COUNT_WIDTH'({rl_hi_new, reload_ext[15:0]});
        end

        if (rd && idx == IDX_COUNT_LO) begin
            shadow_d = count_ext[31:16];
        end

        ack_d = acc && (idx != IDX_RSVD);
        err_d = acc && (idx == IDX_RSVD);
        dat_d = (rd && idx != IDX_RSVD) ? rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            if_q     <= 1'b0;
            presc    <= '0;
            reload   <= RST_RELOAD;
            count    <= RST_RELOAD;
            shadow   <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            ctrl     <= ctrl_d;
            if_q     <= if_d;
            presc    <= presc_d;
            reload   <= reload_d;
            count    <= count_d;
            shadow   <= shadow_d;
            wb_ack_o <= ack_d;
            wb_err_o <= err_d;
            wb_dat_o <= dat_d;
            irq_o    <= if_q & ctrl[CTRL_IE];
        end
    end

endmodule

// File: tb/tb_auv_wb_timer.sv
// Directed self-checking bench for auv_wb_timer.
module tb_auv_wb_timer;
    import auv_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    auv_wb_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_stb_i   (wb_stb_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_stall_o (wb_stall_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    // One access per rising edge; outputs sampled 1ns after the accepting edge.
    task automatic bus_access(input logic we, input reg_idx_e idx, input logic [15:0] wdata,
                              input logic [1:0] sel, output logic ack, output logic err,
                              output logic [15:0] rdata);
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {idx, 1'b0};
        wb_dat_i = wdata;
        wb_sel_i = sel;
        @(posedge clk);
        #1;
        ack   = wb_ack_o;
        err   = wb_err_o;
        rdata = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input reg_idx_e idx, input logic [15:0] wdata);
        logic a, e;
        logic [15:0] d;
        bus_access(1'b1, idx, wdata, 2'b11, a, e, d);
    endtask

    task automatic wb_read(input reg_idx_e idx, output logic [15:0] rdata);
        logic a, e;
        bus_access(1'b0, idx, 16'h0, 2'b11, a, e, rdata);
    endtask

    task automatic test_reset();
        logic a, e;
        logic [15:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wb_ack_o, wb_err_o, wb_stall_o, irq_o, wb_dat_o} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {wb_ack_o, wb_err_o, wb_stall_o, irq_o, wb_dat_o}, 20'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus_access(1'b0, reg_idx_e'(3'(i)), 16'h0, 2'b11, a, e, d);
            checks++;
            if ({a, e, d} !== {1'b1, 1'b0, 16'h0}) begin
                errors++;
                $display("FAIL reset_read_idx%0d: got ack=%b err=%b dat=%h expected ack=1 err=0 dat=0000",
                         i, a, e, d);
            end
            @(posedge clk);
            #1;
            checks++;
            if (wb_ack_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_ack_pulse_idx%0d: got %b expected 0", i, wb_ack_o);
            end
        end
    endtask

    task automatic test_periodic();
        logic [15:0] d;
        wb_write(IDX_PRESC, 16'd3);
        wb_write(IDX_RELOAD_LO, 16'd4);
        wb_write(IDX_RELOAD_HI, 16'd0);
        wb_write(IDX_COUNT_LO, 16'd4);
        wb_write(IDX_COUNT_HI, 16'd0);
        wb_write(IDX_CTRL, 16'b011);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL periodic_irq_early: got %b expected 0", irq_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL periodic_irq_rise: got %b expected 1", irq_o);
        end
        wb_read(IDX_STATUS, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL periodic_status: got %h expected %h", d, 16'h0001);
        end
        wb_read(IDX_COUNT_LO, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL periodic_reload: got %h expected %h", d, 16'h0004);
        end
        wb_write(IDX_STATUS, 16'h0001);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL periodic_irq_hold: got %b expected 1", irq_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL periodic_irq_fall: got %b expected 0", irq_o);
        end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL periodic_irq_early2: got %b expected 0", irq_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL periodic_irq_rise2: got %b expected 1", irq_o);
        end
        wb_write(IDX_STATUS, 16'h0001);
        wb_write(IDX_CTRL, 16'h0000);
    endtask

    task automatic test_oneshot();
        logic [15:0] d;
        wb_write(IDX_PRESC, 16'd0);
        wb_write(IDX_COUNT_LO, 16'd2);
        wb_write(IDX_COUNT_HI, 16'd0);
        wb_write(IDX_CTRL, 16'b101);
        repeat (3) @(posedge clk);
        wb_read(IDX_CTRL, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL oneshot_ctrl: got %h expected %h", d, 16'h0004);
        end
        wb_read(IDX_STATUS, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL oneshot_if: got %h expected %h", d, 16'h0001);
        end
        wb_read(IDX_COUNT_LO, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL oneshot_reload: got %h expected %h", d, 16'h0004);
        end
        repeat (5) @(posedge clk);
        wb_read(IDX_COUNT_LO, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL oneshot_frozen: got %h expected %h", d, 16'h0004);
        end
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_masked: got %b expected 0", irq_o);
        end
        wb_write(IDX_STATUS, 16'h0001);
    endtask

    task automatic test_back_to_back();
        logic [15:0] lo, hi;
        wb_write(IDX_COUNT_LO, 16'h0000);
        wb_write(IDX_COUNT_HI, 16'h0001);
        wb_write(IDX_CTRL, 16'b001);
        wb_read(IDX_COUNT_LO, lo);
        wb_read(IDX_COUNT_HI, hi);
        checks++;
        if ({hi, lo} !== 32'h0001_0000) begin
            errors++;
            $display("FAIL atomic_count_wrap: got %h expected %h", {hi, lo}, 32'h0001_0000);
        end
        wb_write(IDX_CTRL, 16'b000);
        wb_read(IDX_COUNT_LO, lo);
        wb_read(IDX_COUNT_HI, hi);
        checks++;
        if ({hi, lo} !== 32'h0000_FFFD) begin
            errors++;
            $display("FAIL atomic_count_after: got %h expected %h", {hi, lo}, 32'h0000_FFFD);
        end
    endtask

    task automatic test_reserved_and_sel();
        logic a, e;
        logic [15:0] d;
        bus_access(1'b0, IDX_RSVD, 16'h0, 2'b11, a, e, d);
        checks++;
        if ({a, e, d} !== {1'b0, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL rsvd_read: got ack=%b err=%b dat=%h expected ack=0 err=1 dat=0000", a, e, d);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({wb_ack_o, wb_err_o} !== 2'b00) begin
            errors++;
            $display("FAIL rsvd_err_pulse: got %b expected 00", {wb_ack_o, wb_err_o});
        end
        bus_access(1'b1, IDX_RSVD, 16'hFFFF, 2'b11, a, e, d);
        checks++;
        if ({a, e, d} !== {1'b0, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL rsvd_write: got ack=%b err=%b dat=%h expected ack=0 err=1 dat=0000", a, e, d);
        end
        wb_read(IDX_CTRL, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL rsvd_no_side_effect: got %h expected %h", d, 16'h0000);
        end
        bus_access(1'b1, IDX_PRESC, 16'hABCD, 2'b01, a, e, d);
        wb_read(IDX_PRESC, d);
        checks++;
        if (d !== 16'h00CD) begin
            errors++;
            $display("FAIL sel_low_lane: got %h expected %h", d, 16'h00CD);
        end
        bus_access(1'b1, IDX_PRESC, 16'h12FF, 2'b10, a, e, d);
        wb_read(IDX_PRESC, d);
        checks++;
        if (d !== 16'h12CD) begin
            errors++;
            $display("FAIL sel_high_lane: got %h expected %h", d, 16'h12CD);
        end
        wb_write(IDX_PRESC, 16'h0000);
    endtask

    task automatic test_collisions();
        logic [15:0] d;
        // W1C on the same edge as an expiry
        wb_write(IDX_RELOAD_LO, 16'h0000);
        wb_write(IDX_RELOAD_HI, 16'h0000);
        wb_write(IDX_COUNT_LO, 16'h0000);
        wb_write(IDX_COUNT_HI, 16'h0000);
        wb_write(IDX_CTRL, 16'b001);
        wb_write(IDX_STATUS, 16'h0001);
        wb_read(IDX_STATUS, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL coll_w1c_vs_set: got %h expected %h", d, 16'h0001);
        end
        wb_write(IDX_CTRL, 16'b000);
        wb_write(IDX_STATUS, 16'h0001);
        wb_read(IDX_STATUS, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL coll_w1c_idle: got %h expected %h", d, 16'h0000);
        end
        // COUNT write on the same edge as a tick at COUNT==0
        wb_write(IDX_CTRL, 16'b001);
        wb_write(IDX_COUNT_LO, 16'h0007);
        wb_write(IDX_CTRL, 16'b000);
        wb_read(IDX_STATUS, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL coll_count_no_expiry: got %h expected %h", d, 16'h0000);
        end
        wb_read(IDX_COUNT_LO, d);
        checks++;
        if (d !== 16'h0006) begin
            errors++;
            $display("FAIL coll_count_write_wins: got %h expected %h", d, 16'h0006);
        end
        // CTRL write on the same edge as a one-shot expiry
        wb_write(IDX_COUNT_LO, 16'h0000);
        wb_write(IDX_CTRL, 16'b101);
        wb_write(IDX_CTRL, 16'b101);
        wb_read(IDX_CTRL, d);
        checks++;
        if (d !== 16'h0005) begin
            errors++;
            $display("FAIL coll_ctrl_write_wins: got %h expected %h", d, 16'h0005);
        end
        wb_write(IDX_CTRL, 16'b000);
        wb_write(IDX_STATUS, 16'h0001);
        // Reset while an ack is outstanding
        wb_write(IDX_CTRL, 16'b011);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL coll_irq_before_reset: got %b expected 1", irq_o);
        end
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = {IDX_CTRL, 1'b0};
        wb_sel_i = 2'b11;
        @(posedge clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL coll_ack_pending: got %b expected 1", wb_ack_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_ack_o, wb_err_o, irq_o, wb_dat_o} !== 19'h0) begin
            errors++;
            $display("FAIL coll_reset_cancel: got %h expected %h",
                     {wb_ack_o, wb_err_o, irq_o, wb_dat_o}, 19'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({wb_ack_o, irq_o} !== 2'b00) begin
            errors++;
            $display("FAIL coll_reset_hold: got %b expected 00", {wb_ack_o, irq_o});
        end
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        rst_n    = 1'b1;
        wb_read(IDX_CTRL, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL coll_post_reset_ctrl: got %h expected %h", d, 16'h0000);
        end
        wb_read(IDX_STATUS, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL coll_post_reset_status: got %h expected %h", d, 16'h0000);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_back_to_back();
        test_reserved_and_sel();
        test_collisions();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
